// File: rtl/ecc_core_if.sv
// Operand/result bundle for ecc_core: the requester (master) drives the operation,
// the core (slave) returns the result, error count and status.
interface ecc_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            ctrl;
  logic [1:0]            codeword_width;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] noise;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            num_of_errors;
  logic                  operation_done;
  logic                  busy;

  modport master (
    output start, ctrl, codeword_width, data_in, noise,
    input  data_out, num_of_errors, operation_done, busy
  );

  modport slave (
    input  start, ctrl, codeword_width, data_in, noise,
    output data_out, num_of_errors, operation_done, busy
  );
endinterface

// File: rtl/ecc_core.sv
// Extended-Hamming encoder/decoder for 8/16/32-bit codewords, sequenced by a small FSM.
// Define ECC_FULL_CHANNEL_EN to add the encode -> noise -> decode operation (ctrl=2).
module ecc_core #(
  parameter int DATA_WIDTH = 32
) (
  input logic       PCLK,
  input logic       PRESETn,
  ecc_core_if.slave bus
);

  localparam logic [1:0] OP_ENCODE = 2'd0;
  localparam logic [1:0] OP_DECODE = 2'd1;

`ifdef ECC_FULL_CHANNEL_EN
  localparam logic [1:0] OP_FULL = 2'd2;
  typedef enum logic [2:0] {IDLE, ENC, CHAN, SYND, CORR, DONE} stateT;
  localparam stateT AFTER_ENC = CHAN;
`else
  typedef enum logic [2:0] {IDLE, ENC, SYND, CORR, DONE} stateT;
  localparam stateT AFTER_ENC = SYND;
`endif

  function automatic logic [31:0] dataMask(input logic [1:0] wSel);
    logic [31:0] m;
    case (wSel)
      2'd0:    m = 32'h0000_000F;
      2'd1:    m = 32'h0000_07FF;
      default: m = 32'h03FF_FFFF;
    endcase
    return m;
  endfunction

  // Data bit j sits at the j-th non-power-of-two Hamming position; parity slots stay empty.
  function automatic logic [31:0] placeData(input logic [31:0] d);
    logic [31:0] vec;
    int j;
    vec = '0;
    j = 0;
    for (int pos = 3; pos < 32; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        vec[pos[4:0]] = d[j[4:0]];
        j++;
      end
    end
    return vec;
  endfunction

  function automatic logic [31:0] gatherData(input logic [31:0] vec);
    logic [31:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 3; pos < 32; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j[4:0]] = vec[pos[4:0]];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [4:0] posSyndrome(input logic [31:0] vec);
    logic [4:0] s;
    s = '0;
    for (int pos = 1; pos < 32; pos++) begin
      if (vec[pos[4:0]]) s = s ^ pos[4:0];
    end
    return s;
  endfunction

  // Codeword = {overall parity, p_{P-2}..p_0, data}; the overall bit also covers the parity bits.
  function automatic logic [31:0] encodeWord(input logic [31:0] d, input logic [1:0] wSel);
    logic [31:0] dk;
    logic [4:0]  p;
    logic [31:0] cw;
    dk = d & dataMask(wSel);
    p  = posSyndrome(placeData(dk));
    case (wSel)
      2'd0:    cw = {24'd0, (^dk) ^ (^p[2:0]), p[2:0], dk[3:0]};
      2'd1:    cw = {16'd0, (^dk) ^ (^p[3:0]), p[3:0], dk[10:0]};
      default: cw = {(^dk) ^ (^p), p, dk[25:0]};
    endcase
    return cw;
  endfunction

  stateT                 state;
  logic [1:0]            capWidth;
  logic [DATA_WIDTH-1:0] capData;
  logic [DATA_WIDTH-1:0] cwReg;
  logic [4:0]            synReg;
  logic                  overallReg;
  logic [DATA_WIDTH-1:0] dataOut;
  logic [1:0]            numErrors;
  logic                  operationDone;
  logic                  busyReg;
  logic                  opLegal;
  logic                  encodeOnly;
  logic [31:0]           encWord;
  logic [31:0]           rxData;
  logic [4:0]            rxParity;
  logic                  rxOverall;
  logic [4:0]            rxSyndrome;
  logic [31:0]           corrData;

`ifdef ECC_FULL_CHANNEL_EN
  logic [1:0]            capCtrl;
  logic [DATA_WIDTH-1:0] capNoise;
  assign opLegal    = (bus.ctrl != 2'd3);
  assign encodeOnly = (capCtrl == OP_ENCODE);
`else
  logic unusedNoise;
  assign unusedNoise = ^bus.noise;
  assign opLegal     = (bus.ctrl == OP_ENCODE) || (bus.ctrl == OP_DECODE);
  assign encodeOnly  = 1'b1;
`endif

  // Split the working codeword into its fields and derive syndrome and corrected data.
  always_comb begin
    rxData    = '0;
    rxParity  = '0;
    rxOverall = 1'b0;
    encWord   = encodeWord(capData, capWidth);
    case (capWidth)
      2'd0: begin
        rxData    = {28'd0, cwReg[3:0]};
        rxParity  = {2'd0, cwReg[6:4]};
        rxOverall = ^cwReg[7:0];
      end
      2'd1: begin
        rxData    = {21'd0, cwReg[10:0]};
        rxParity  = {1'b0, cwReg[14:11]};
        rxOverall = ^cwReg[15:0];
      end
      default: begin
        rxData    = {6'd0, cwReg[25:0]};
        rxParity  = cwReg[30:26];
        rxOverall = ^cwReg;
      end
    endcase
    rxSyndrome = posSyndrome(placeData(rxData)) ^ rxParity;
    corrData   = rxData ^ (gatherData(32'd1 << synReg) & dataMask(capWidth));
  end

  // Sequencer: results and the done pulse are registered on the edge that enters DONE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      capWidth      <= '0;
      capData       <= '0;
      cwReg         <= '0;
      synReg        <= '0;
      overallReg    <= 1'b0;
      dataOut       <= '0;
      numErrors     <= '0;
      operationDone <= 1'b0;
      busyReg       <= 1'b0;
`ifdef ECC_FULL_CHANNEL_EN
      capCtrl       <= '0;
      capNoise      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && opLegal) begin
            capWidth <= bus.codeword_width;
            capData  <= bus.data_in;
            cwReg    <= bus.data_in;
            busyReg  <= 1'b1;
`ifdef ECC_FULL_CHANNEL_EN
            capCtrl  <= bus.ctrl;
            capNoise <= bus.noise;
`endif
            state    <= (bus.ctrl == OP_DECODE) ? SYND : ENC;
          end
        end
        ENC: begin
          cwReg <= encWord;
          if (encodeOnly) begin
            dataOut       <= encWord;
            numErrors     <= 2'd0;
            operationDone <= 1'b1;
            state         <= DONE;
          end else begin
            state <= AFTER_ENC;
          end
        end
`ifdef ECC_FULL_CHANNEL_EN
        CHAN: begin
          cwReg <= cwReg ^ capNoise;
          state <= SYND;
        end
`endif
        SYND: begin
          synReg     <= rxSyndrome;
          overallReg <= rxOverall;
          state      <= CORR;
        end
        CORR: begin
          if (overallReg) begin
            dataOut   <= corrData;
            numErrors <= 2'd1;
          end else if (synReg != 5'd0) begin
            dataOut   <= rxData;
            numErrors <= 2'd2;
          end else begin
            dataOut   <= rxData;
            numErrors <= 2'd0;
          end
          operationDone <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          operationDone <= 1'b0;
          busyReg       <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out       = dataOut;
  assign bus.num_of_errors  = numErrors;
  assign bus.operation_done = operationDone;
  assign bus.busy           = busyReg;

endmodule

// File: tb/tb_ecc_core.sv
// Directed self-checking bench for ecc_core: encode/decode vectors, ignored starts,
// mid-operation input changes and reset abort; honours ECC_FULL_CHANNEL_EN for ctrl=2.
module tb_ecc_core;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   failures;
  int   doneEdge;
  int   doneCount;
  int   doneSeen;
  logic [31:0] res;
  logic [31:0] errs;
  logic [31:0] busyFirst;
  logic [31:0] busyEnd;

  ecc_core_if #(.DATA_WIDTH(32)) bus();

  ecc_core #(.DATA_WIDTH(32)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one start, watch 8 edges and record the first done pulse; optionally disturb inputs.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] wSel, input logic [31:0] data,
                               input logic [31:0] nz, input bit disturb);
    @(negedge PCLK);
    bus.start          = 1'b1;
    bus.ctrl           = op;
    bus.codeword_width = wSel;
    bus.data_in        = data;
    bus.noise          = nz;
    doneEdge  = 0;
    doneCount = 0;
    res       = '0;
    errs      = '0;
    busyFirst = '0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge PCLK);
      #1;
      if (e == 1) begin
        busyFirst = 32'(bus.busy);
        bus.start = disturb;
        if (disturb) begin
          bus.data_in        = ~data;
          bus.noise          = ~nz;
          bus.codeword_width = 2'd2;
          bus.ctrl           = op ^ 2'd1;
        end
      end else begin
        bus.start = 1'b0;
      end
      if (bus.operation_done) begin
        doneCount++;
        if (doneEdge == 0) begin
          doneEdge = e;
          res      = bus.data_out;
          errs     = 32'(bus.num_of_errors);
        end
      end
    end
    busyEnd = 32'(bus.busy);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    PRESETn  = 1'b0;
    bus.start = 1'b0;
    bus.ctrl = 2'd0;
    bus.codeword_width = 2'd0;
    bus.data_in = '0;
    bus.noise = '0;
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("rstDataOut", bus.data_out, 32'h0);
    checkOutput("rstErrors", 32'(bus.num_of_errors), 32'h0);
    checkOutput("rstDone", 32'(bus.operation_done), 32'h0);
    checkOutput("rstBusy", 32'(bus.busy), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    applyStimulus(2'd0, 2'd0, 32'h0000_000B, 32'h0, 1'b0);
    checkOutput("encW8Edge", 32'(doneEdge), 32'd2);
    checkOutput("encW8Data", res, 32'h0000_001B);
    checkOutput("encW8Err", errs, 32'd0);
    checkOutput("encW8Count", 32'(doneCount), 32'd1);
    checkOutput("encW8BusyFirst", busyFirst, 32'd1);
    checkOutput("encW8BusyEnd", busyEnd, 32'd0);

    applyStimulus(2'd1, 2'd0, 32'h0000_001B, 32'h0, 1'b0);
    checkOutput("decCleanEdge", 32'(doneEdge), 32'd3);
    checkOutput("decCleanData", res, 32'h0000_000B);
    checkOutput("decCleanErr", errs, 32'd0);

    applyStimulus(2'd1, 2'd0, 32'h0000_001A, 32'h0, 1'b0);
    checkOutput("decSingleEdge", 32'(doneEdge), 32'd3);
    checkOutput("decSingleData", res, 32'h0000_000B);
    checkOutput("decSingleErr", errs, 32'd1);

    applyStimulus(2'd1, 2'd0, 32'h0000_0018, 32'h0, 1'b0);
    checkOutput("decDoubleEdge", 32'(doneEdge), 32'd3);
    checkOutput("decDoubleData", res, 32'h0000_0008);
    checkOutput("decDoubleErr", errs, 32'd2);

    applyStimulus(2'd2, 2'd0, 32'h0000_000B, 32'h0000_0010, 1'b0);
`ifdef ECC_FULL_CHANNEL_EN
    checkOutput("fullEdge", 32'(doneEdge), 32'd5);
    checkOutput("fullData", res, 32'h0000_000B);
    checkOutput("fullErr", errs, 32'd1);
`else
    checkOutput("fullIgnoredDone", 32'(doneCount), 32'd0);
    checkOutput("fullIgnoredBusy", busyFirst, 32'd0);
`endif

    applyStimulus(2'd3, 2'd0, 32'h0000_000B, 32'h0, 1'b0);
    checkOutput("reservedDone", 32'(doneCount), 32'd0);
    checkOutput("reservedBusy", busyFirst, 32'd0);

    applyStimulus(2'd0, 2'd0, 32'h0000_000B, 32'h0, 1'b1);
    checkOutput("disturbCount", 32'(doneCount), 32'd1);
    checkOutput("disturbEdge", 32'(doneEdge), 32'd2);
    checkOutput("disturbData", res, 32'h0000_001B);

    applyStimulus(2'd1, 2'd0, 32'h0000_0018, 32'h0, 1'b0);
    checkOutput("preRstData", res, 32'h0000_0008);

    @(negedge PCLK);
    bus.start = 1'b1;
    bus.ctrl = 2'd1;
    bus.codeword_width = 2'd0;
    bus.data_in = 32'h0000_001A;
    @(posedge PCLK);
    #1;
    bus.start = 1'b0;
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("abortDataOut", bus.data_out, 32'h0);
    checkOutput("abortErrors", 32'(bus.num_of_errors), 32'h0);
    checkOutput("abortBusy", 32'(bus.busy), 32'h0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge PCLK);
      #1;
      if (bus.operation_done) doneSeen++;
    end
    checkOutput("abortNoDone", 32'(doneSeen), 32'd0);
    #2;
    PRESETn = 1'b1;

    applyStimulus(2'd1, 2'd0, 32'h0000_001A, 32'h0, 1'b0);
    checkOutput("postRstEdge", 32'(doneEdge), 32'd3);
    checkOutput("postRstData", res, 32'h0000_000B);
    checkOutput("postRstErr", errs, 32'd1);

    applyStimulus(2'd0, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    checkOutput("encW16Ones", res, 32'h0000_FFFF);
    applyStimulus(2'd1, 2'd1, 32'h0000_FFFF, 32'h0, 1'b0);
    checkOutput("decW16OnesData", res, 32'h0000_07FF);
    checkOutput("decW16OnesErr", errs, 32'd0);

    applyStimulus(2'd0, 2'd1, 32'h0000_0001, 32'h0, 1'b0);
    checkOutput("encW16Bit0", res, 32'h0000_9801);

    applyStimulus(2'd0, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0);
    checkOutput("encW32Ones", res, 32'hFFFF_FFFF);
    applyStimulus(2'd1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0);
    checkOutput("decW32OnesData", res, 32'h03FF_FFFF);
    checkOutput("decW32OnesErr", errs, 32'd0);

    applyStimulus(2'd1, 2'd2, 32'hFFFF_FFFE, 32'h0, 1'b0);
    checkOutput("decW32FlipData", res, 32'h03FF_FFFF);
    checkOutput("decW32FlipErr", errs, 32'd1);

    applyStimulus(2'd0, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b0);
    checkOutput("encW3As32", res, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_core.md
ECC_CORE -- requirements
Module: ecc_core

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the data and codeword buses; only 32 is legal.
REQ-002 PCLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle operation request from the register stage.
REQ-005 ctrl  in  2  operation: 0 encode, 1 decode, 2 full channel, 3 reserved.
REQ-006 codeword_width  in  2  W: 0=8, 1=16, 2=32; 3 treated as 32.
REQ-007 data_in  in  DATA_WIDTH  data word (encode, full channel) or received codeword (decode).
REQ-008 noise  in  DATA_WIDTH  error pattern XORed onto the codeword in full channel.
REQ-009 data_out  out  DATA_WIDTH  codeword (encode) or corrected data, zero-extended (decode, full channel).
REQ-010 num_of_errors  out  2  0 none, 1 corrected, 2 uncorrectable; 0 after encode.
REQ-011 operation_done  out  1  one-cycle completion pulse.
REQ-012 busy  out  1  high from the sampling edge until the DONE state has been left.

Function
REQ-013 Code: extended Hamming; P = 4/5/6 and K = W-P = 4/11/26 for W = 8/16/32.
REQ-014 Data bit j maps to the j-th non-power-of-two position in 1..W-1, ascending; parity p_i (i<P-1) = XOR of data bits whose position has bit i set; p_{P-1} = XOR of all data bits and p_0..p_{P-2}.
REQ-015 Codeword layout: bits K-1:0 = data, bits W-1:K = {p_{P-1}..p_0}, bits above W zero.
REQ-016 Decode: syndrome S = recomputed p_0..p_{P-2} XOR received; Q = XOR of all W received bits.
REQ-017 S=0,Q=0 -> errors 0; Q=1 -> errors 1, flip position S (S=0: overall parity bit, data unchanged); S!=0,Q=0 -> errors 2, data_out = uncorrected data bits.
REQ-018 start, ctrl, codeword_width, data_in, noise are captured on the sampling edge; later input changes do not affect the operation.
REQ-019 FSM states IDLE, ENC, CHAN, SYND, CORR, DONE; encode IDLE-ENC-DONE; decode IDLE-SYND-CORR-DONE; full IDLE-ENC-CHAN-SYND-CORR-DONE; DONE->IDLE unconditionally.
REQ-020 operation_done is high for exactly the DONE cycle, i.e. after the 2nd/3rd/5th rising edge counted from and including the sampling edge, for encode/decode/full.
REQ-021 data_out and num_of_errors update in the cycle operation_done rises and hold until the next DONE or reset.
REQ-022 start while busy is ignored; start with ctrl=3 is ignored (stays IDLE, no pulse, busy stays low).
REQ-023 A start in the DONE cycle is ignored; the first accepted start is in IDLE.

Reset
REQ-024 On PRESETn low, immediately: state IDLE, data_out 0, num_of_errors 0, operation_done 0, busy 0, captured inputs 0.
REQ-025 Reset during an operation aborts it with no operation_done; after release the block accepts start on the first rising edge.

Configuration
REQ-026 Macro ECC_FULL_CHANNEL_EN defined: ctrl=2 performs full channel per REQ-019.
REQ-027 Macro undefined: CHAN state and noise path are absent; ctrl=2 is treated as reserved per REQ-022; noise is unused.

Verification
REQ-028 Encode, W=8, data_in 0x0000000B -> done after 2nd edge, data_out 0x0000001B, errors 0.
REQ-029 Decode, W=8, data_in 0x1B -> data_out 0x0B, errors 0; data_in 0x1A -> data_out 0x0B, errors 1; data_in 0x18 -> errors 2; done after 3rd edge each.
REQ-030 Full channel (macro defined), W=8, data_in 0x0B, noise 0x10 -> done after 5th edge, data_out 0x0B, errors 1; macro undefined -> no done, busy stays 0.
REQ-031 Start pulsed again while busy, and data_in changed mid-operation -> exactly one done with the originally captured result.
REQ-032 PRESETn asserted in the SYND state -> all outputs 0 at once, no done; next start after release completes normally.
REQ-033 Encode W=16 and W=32 sweeps of all-ones data -> codeword bits above W are 0; decode of each codeword returns the data with errors 0.
